// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry skid buffer (XLEN 32/64).
// Define IMM_ILLEGAL_CHK_EN to register err=1 for the reserved select 3'b111.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel_ext,
    input  logic [31:0]      instr,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] tag_out,
    output logic             err
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              skid_valid;
    logic              acc;
    logic              load_out;
    logic              load_skid;
    logic              move_skid;
    logic [31:0]       v;
    logic [XLEN-1:0]   dec_imm;
    logic [XLEN-1:0]   skid_imm;
    logic [TAG_W-1:0]  skid_tag;
    logic              unused_opcode;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    assign unused_opcode = ^instr[6:0];

    // Every format is first formed as a 32-bit value whose bit 31 is the
    // extension bit, so widening to XLEN is a single replication.
    always_comb begin
        v = '0;
        unique case (sel_ext)
            3'b000: v = {{20{instr[31]}}, instr[31:20]};
            3'b001: v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: v = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            3'b011: v = {instr[31:12], 12'b0};
            3'b100: v = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
            3'b101: v = {27'b0, instr[19:15]};
            3'b110: v = (XLEN == 64) ? {26'b0, instr[25:20]}
                                     : {27'b0, instr[24:20]};
            3'b111: v = '0;
        endcase
        dec_imm = {{(XLEN-31){v[31]}}, v[30:0]};
    end

    assign skid_valid = (state == TWO);
    assign in_ready   = !skid_valid;
    assign out_valid  = (state != EMPTY);
    assign acc        = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (acc) begin
                    state_n  = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (acc && out_ready) begin
                    load_out = 1'b1;
                end else if (acc) begin
                    state_n   = TWO;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_n = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    state_n   = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm      <= '0;
            tag_out  <= '0;
            skid_imm <= '0;
            skid_tag <= '0;
        end else begin
            if (load_out) begin
                imm     <= dec_imm;
                tag_out <= tag_in;
            end else if (move_skid) begin
                imm     <= skid_imm;
                tag_out <= skid_tag;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_tag <= tag_in;
            end
        end
    end

`ifdef IMM_ILLEGAL_CHK_EN
    logic out_err;
    logic skid_err;
    logic dec_err;

    assign dec_err = (sel_ext == 3'b111);
    assign err     = out_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_err  <= 1'b0;
            skid_err <= 1'b0;
        end else begin
            if (load_out) begin
                out_err <= dec_err;
            end else if (move_skid) begin
                out_err <= skid_err;
            end
            if (load_skid) begin
                skid_err <= dec_err;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances
// driven in lockstep from one directed stimulus sequence.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  sel_ext;
    logic [31:0] instr;
    logic [31:0] tag_in;

    logic        in_ready_a, out_valid_a, err_a;
    logic [31:0] imm_a, tag_a;
    logic        in_ready_b, out_valid_b, err_b;
    logic [63:0] imm_b;
    logic [31:0] tag_b;

    typedef struct packed {
        logic [31:0] e32;
        logic [63:0] e64;
        logic [31:0] tag;
        logic        err;
    } ent_t;

    ent_t        q[$];
    logic [31:0] popped[$];
    int          checks = 0;
    int          errors = 0;

`ifdef IMM_ILLEGAL_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .sel_ext(sel_ext), .instr(instr), .tag_in(tag_in),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .imm(imm_a), .tag_out(tag_a), .err(err_a)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .sel_ext(sel_ext), .instr(instr), .tag_in(tag_in),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .imm(imm_b), .tag_out(tag_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode via arithmetic shifts of a left-aligned field.
    function automatic logic [63:0] model(logic [2:0] s, logic [31:0] w,
                                          bit x64);
        logic signed [63:0] r;
        r = '0;
        case (s)
            3'd0: r = $signed(w) >>> 20;
            3'd1: r = $signed({w[31:25], w[11:7], 20'b0}) >>> 20;
            3'd2: r = $signed({w[31], w[7], w[30:25], w[11:8],
                               1'b0, 19'b0}) >>> 19;
            3'd3: r = $signed({w[31:12], 12'b0});
            3'd4: r = $signed({w[31], w[19:12], w[20], w[30:21],
                               1'b0, 11'b0}) >>> 11;
            3'd5: r = {59'b0, w[19:15]};
            3'd6: r = x64 ? {58'b0, w[25:20]} : {59'b0, w[24:20]};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic exp_err(logic [2:0] s);
        return (s == 3'b111) & CHK;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid_a", out_valid_a, q.size() != 0);
            chk("out_valid_b", out_valid_b, q.size() != 0);
            chk("in_ready_a", in_ready_a, q.size() < 2);
            chk("in_ready_b", in_ready_b, q.size() < 2);
            if (out_valid_a && q.size() != 0) begin
                chk("imm_a", imm_a, q[0].e32);
                chk("imm_b", imm_b, q[0].e64);
                chk("tag_a", tag_a, q[0].tag);
                chk("tag_b", tag_b, q[0].tag);
                chk("err_a", err_a, q[0].err);
                chk("err_b", err_b, q[0].err);
                if (out_ready) begin
                    popped.push_back(q[0].tag);
                    q.delete(0);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(logic [2:0] s, logic [31:0] w, logic [31:0] t,
                        logic [31:0] e32, logic [63:0] e64);
        ent_t e;
        bit   done;
        done     = 1'b0;
        in_valid = 1'b1;
        sel_ext  = s;
        instr    = w;
        tag_in   = t;
        e.e32    = e32;
        e.e64    = e64;
        e.tag    = t;
        e.err    = exp_err(s);
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            #1;
            if (in_ready_a) begin
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic send_m(logic [2:0] s, logic [31:0] w, logic [31:0] t);
        logic [63:0] m32;
        m32 = model(s, w, 1'b0);
        send(s, w, t, m32[31:0], model(s, w, 1'b1));
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel_ext   = '0;
        instr     = '0;
        tag_in    = '0;
        rst       = 1'b1;
        #12;
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_imm_a", imm_a, 0);
        chk("rst_imm_b", imm_b, 0);
        chk("rst_tag", tag_a, 0);
        chk("rst_err", err_a, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready_a, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        send(3'd0, 32'hFFF00093, 32'h100, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        send(3'd1, 32'hFE112E23, 32'h101, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
        send(3'd4, 32'hFF9FF06F, 32'h102, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8);
        send(3'd3, 32'h800000B7, 32'h103, 32'h80000000, 64'hFFFFFFFF80000000);
        send(3'd6, 32'h03F0D093, 32'h104, 32'h0000001F, 64'h000000000000003F);
        send(3'd7, 32'hFFFFFFFF, 32'h105, 32'h0, 64'h0);
        send_m(3'd2, 32'h8E000AE3, 32'h106);
        send_m(3'd5, 32'h000FD073, 32'h107);
        for (int i = 0; i < 10; i++) begin
            send_m(3'($urandom_range(0, 7)), $urandom, 32'(200 + i));
        end
        in_valid = 1'b0;
        drain();

        out_ready = 1'b0;
        fork
            begin
                send_m(3'd0, 32'h00A00093, 32'd1);
                send_m(3'd1, 32'h00112623, 32'd2);
                send_m(3'd4, 32'h0080006F, 32'd3);
                send_m(3'd3, 32'hFFFFF0B7, 32'd4);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                chk("bp_in_ready", in_ready_a, 0);
                chk("bp_head_tag", tag_a, 1);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        n = popped.size();
        chk("pop_count", n, 22);
        if (n >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("bp_order", popped[n-4+k], k + 1);
            end
        end

        out_ready = 1'b0;
        send_m(3'd0, 32'h7FF00093, 32'h300);
        send_m(3'd2, 32'hFE000EE3, 32'h301);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("arst_out_valid_a", out_valid_a, 0);
        chk("arst_out_valid_b", out_valid_b, 0);
        chk("arst_imm_a", imm_a, 0);
        chk("arst_imm_b", imm_b, 0);
        chk("arst_tag", tag_a, 0);
        chk("arst_in_ready", in_ready_a, 1);
        chk("arst_err", err_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_m(3'd5, 32'h0007D073, 32'h400);
        in_valid = 1'b0;
        drain();
        chk("pop_count_final", popped.size(), 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It accepts a 32-bit instruction word and an immediate-format select through a valid/ready handshake. It produces an XLEN-wide extended immediate one cycle later, with a 2-entry skid buffer so backpressure never drops or duplicates a transfer. It supports XLEN=32 or 64 and adds CSR-zimm and shift-amount formats, and passes a tag (e.g. PC) through alongside the immediate.

Parameters:
XLEN, 32, output immediate width; legal values 32 and 64 only.
TAG_W, 32, width of the sideband tag carried with each immediate.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream has a valid instruction.
in_ready  output  1  block can accept a transfer this cycle.
sel_ext  input  3  immediate format select.
instr  input  32  instruction word; bits [6:0] are ignored.
tag_in  input  TAG_W  sideband tag.
out_valid  output  1  imm/tag_out hold a valid result.
out_ready  input  1  downstream accepts a result.
imm  output  XLEN  extended immediate.
tag_out  output  TAG_W  tag matching imm.
err  output  1  illegal sel_ext flag (see Optional Feature).

Behaviour:
- Reset (async, active-high) clears:
  - the output register: out_valid=0, imm=0, tag_out=0, err=0;
  - the skid register (skid_valid=0).
  - in_ready=1 once rst deasserts.
- Transfers:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- in_ready = !skid_valid. This is combinational from state only, never from in_valid or out_ready.
- Immediate decode is combinational on instr/sel_ext. All results are sign-extended to XLEN from the top bit of the formed value unless stated otherwise.
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 U: {instr[31:12], 12'b0}. For XLEN=64, bits [63:32] copy instr[31].
  - 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 101 Z: zero-extend instr[19:15] (CSR zimm).
  - 110 SH: zero-extend instr[24:20] when XLEN=32; zero-extend instr[25:20] when XLEN=64.
  - 111: reserved; imm=0.
- State machine, with states {EMPTY, ONE (output reg valid), TWO (output + skid valid)}:
  - EMPTY, input transfer -> ONE; result appears with out_valid=1 the next cycle (latency 1).
  - ONE, input transfer with out_ready=1 -> stay ONE; output reg reloads with the new result (1 transfer/cycle throughput).
  - ONE, input transfer with out_ready=0 -> TWO; the new result goes to skid, output reg holds.
  - ONE, no input, out_ready=1 -> EMPTY; out_valid=0 next cycle.
  - TWO, out_ready=1 -> ONE; skid moves to the output reg and skid_valid clears. No input is accepted this cycle because in_ready=0.
  - TWO, out_ready=0 -> hold everything.
- While out_valid=1 and out_ready=0, imm, tag_out and err are held stable.
- Ordering is strict FIFO. No transfer is lost or duplicated.
- Reset mid-operation discards both entries immediately (async); no partial outputs are produced.
- Only the upstream controls instr/sel_ext contents; the decode values are registered at acceptance.
- XLEN values other than 32/64 are illegal (elaboration error required).

Optional Feature:
Macro IMM_ILLEGAL_CHK_EN.
- Defined: sel_ext=111 registers err=1 with imm=0, travels with its entry through the skid buffer, and is held like imm. Legal formats register err=0.
- Undefined: err is tied to 0. sel_ext=111 still yields imm=0. No extra state is added.

Test Plan:
- XLEN=32, sel_ext=000, instr=0xFFF00093, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, tag_out=tag_in.
- sel_ext=001, instr=0xFE112E23 -> imm=0xFFFFFFFC. sel_ext=100, instr=0xFF9FF06F -> imm=0xFFFFFFF8.
- XLEN=64, sel_ext=011, instr=0x800000B7 -> imm=0xFFFFFFFF80000000. sel_ext=110, instr=0x03F0D093 -> imm=0x3F.
- Backpressure: stream of 4 tagged transfers, out_ready=0 for 3 cycles. Required:
  - in_ready=0 after 2 accepts;
  - outputs held stable while stalled;
  - on release, tags emerge 1,2,3,4 in order, none dropped or duplicated.
- Assert rst asynchronously while in state TWO -> out_valid=0, imm=0, in_ready=1 immediately, without waiting for a clock edge.
- With IMM_ILLEGAL_CHK_EN defined, sel_ext=111 -> imm=0, err=1. Without it -> imm=0, err=0.
